// File: rtl/core_memory_arbiter_pkg.sv
// ============================================================================
//  Module   : core_memory_arbiter_pkg
//  Brief    : Shared constants and helpers for the shared-memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package core_memory_arbiter_pkg;

    localparam int c_ARB_ROUND_ROBIN = 0;
    localparam int c_ARB_FIXED       = 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_picker.sv
// ============================================================================
//  Module   : rr_priority_picker
//  Brief    : Combinational one-hot winner select, round-robin or fixed priority.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_priority_picker
    import core_memory_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]               i_req,
    input  logic [clog2_min1(NUM_MASTERS)-1:0]   i_ptr,
    input  logic                                 i_fixed,
    output logic [NUM_MASTERS-1:0]               o_winner
);

    localparam int c_PW = clog2_min1(NUM_MASTERS);

    logic            w_found;
    logic [c_PW-1:0] w_idx;

    // Fixed priority is a round-robin scan that always starts at index 0.
    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_idx = c_PW'(((i_fixed ? 0 : int'(i_ptr)) + k) % NUM_MASTERS);
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_memory_arbiter.sv
// ============================================================================
//  Module   : core_memory_arbiter
//  Brief    : N-master shared-memory arbiter with lock and response timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module core_memory_arbiter
    import core_memory_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_WIDTH      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS-1:0]            m_read,
    input  logic [NUM_MASTERS-1:0]            m_write,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_address,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_write_data,
    output logic [BUS_WIDTH-1:0]              m_read_data,
    output logic [NUM_MASTERS-1:0]            m_response,
    output logic                              m_error,
    input  logic                              lock_enable,
    input  logic [clog2_min1(NUM_MASTERS)-1:0] lock_master,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [BUS_WIDTH-1:0]              mem_write_data,
    input  logic [BUS_WIDTH-1:0]              mem_read_data,
    input  logic                              mem_response
);

    localparam int              c_PW         = clog2_min1(NUM_MASTERS);
    localparam int              c_TW         = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic            c_TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic            c_FIXED      = (ARB_MODE == c_ARB_FIXED);

    logic [1:0]             r_state;
    logic [c_PW-1:0]        r_ptr;
    logic [c_TW-1:0]        r_timer;
    logic [NUM_MASTERS-1:0] r_grant;
    logic                   r_mem_read;
    logic                   r_mem_write;
    logic [ADDR_WIDTH-1:0]  r_mem_address;
    logic [BUS_WIDTH-1:0]   r_mem_write_data;
    logic [NUM_MASTERS-1:0] r_m_response;
    logic                   r_m_error;
    logic [BUS_WIDTH-1:0]   r_m_read_data;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_masked;
    logic [NUM_MASTERS-1:0] w_winner;
    logic                   w_sel_write;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [BUS_WIDTH-1:0]   w_sel_wdata;
    logic [c_PW-1:0]        w_ptr_next;

    assign w_req = m_read | m_write;

    // An out-of-range lock_master leaves the masked vector empty.
    always_comb begin
        w_masked = w_req;
        if (lock_enable) begin
            w_masked = '0;
            if (32'(lock_master) < NUM_MASTERS)
                w_masked[lock_master] = w_req[lock_master];
        end
    end

    rr_priority_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .i_req    (w_masked),
        .i_ptr    (r_ptr),
        .i_fixed  (c_FIXED),
        .o_winner (w_winner)
    );

    // A write request takes precedence when a master raises both strobes.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_winner[i]) begin
                w_sel_write = m_write[i];
                w_sel_addr  = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = m_write_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    always_comb begin
        w_ptr_next = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i])
                w_ptr_next = c_PW'((i + 1) % NUM_MASTERS);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= c_IDLE;
            r_ptr            <= '0;
            r_timer          <= '0;
            r_grant          <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
            r_m_response     <= '0;
            r_m_error        <= 1'b0;
            r_m_read_data    <= '0;
        end else begin
            r_m_response  <= '0;
            r_m_error     <= 1'b0;
            r_m_read_data <= '0;
            case (r_state)
                c_IDLE: begin
                    if (|w_masked) begin
                        r_grant          <= w_winner;
                        r_mem_read       <= ~w_sel_write;
                        r_mem_write      <= w_sel_write;
                        r_mem_address    <= w_sel_addr;
                        r_mem_write_data <= w_sel_wdata;
                        r_timer          <= '0;
                        r_state          <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (mem_response) begin
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_m_response  <= r_grant;
                        r_m_read_data <= r_mem_write ? '0 : mem_read_data;
                        r_state       <= c_RESP;
                    end else if (c_TIMEOUT_EN && (r_timer == c_TIMER_LAST)) begin
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_m_response <= r_grant;
                        r_m_error    <= 1'b1;
                        r_state      <= c_RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                c_RESP: begin
                    r_grant <= '0;
                    r_ptr   <= w_ptr_next;
                    r_timer <= '0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign grant          = r_grant;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign m_response     = r_m_response;
    assign m_error        = r_m_error;
    assign m_read_data    = r_m_read_data;

endmodule

`default_nettype wire
